// File: rtl/match_scheduler_pkg.sv
// Shared types and helpers for the match_scheduler frame replay / score arbitration block.
package match_scheduler_pkg;

  localparam int unsigned StateWidth = 3;

  localparam logic [StateWidth-1:0] StIdleEnc    = 3'd0;
  localparam logic [StateWidth-1:0] StClearEnc   = 3'd1;
  localparam logic [StateWidth-1:0] StCaptureEnc = 3'd2;
  localparam logic [StateWidth-1:0] StReplayEnc  = 3'd3;
  localparam logic [StateWidth-1:0] StCollectEnc = 3'd4;
  localparam logic [StateWidth-1:0] StReportEnc  = 3'd5;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = StIdleEnc,
    StClear   = StClearEnc,
    StCapture = StCaptureEnc,
    StReplay  = StReplayEnc,
    StCollect = StCollectEnc,
    StReport  = StReportEnc
  } state_e;

  // One mean pass plus 2L+1 phase passes.
  function automatic int unsigned pass_count(input int unsigned len);
    return 2 * len + 2;
  endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock RAM; HIGH_PERFORMANCE adds an output register (2-cycle read).
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [((RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1)-1:0] addra,
  input  logic [((RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]                                 dina,
  input  logic [RAM_WIDTH-1:0]                                 dinb,
  input  logic                                                 clka,
  input  logic                                                 wea,
  input  logic                                                 web,
  input  logic                                                 ena,
  input  logic                                                 enb,
  input  logic                                                 rsta,
  input  logic                                                 rstb,
  input  logic                                                 regcea,
  input  logic                                                 regceb,
  output logic [RAM_WIDTH-1:0]                                 douta,
  output logic [RAM_WIDTH-1:0]                                 doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  // Both ports share one process so the array has a single driver.
  always_ff @(posedge clka) begin
    if (ena) begin
      ram_data_a <= mem[addra];
      if (wea) mem[addra] <= dina;
    end
    if (enb) begin
      ram_data_b <= mem[addrb];
      if (web) mem[addrb] <= dinb;
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] douta_q;
    logic [RAM_WIDTH-1:0] doutb_q;

    always_ff @(posedge clka) begin
      if (rsta) douta_q <= '0;
      else if (regcea) douta_q <= ram_data_a;
      if (rstb) doutb_q <= '0;
      else if (regceb) doutb_q <= ram_data_b;
    end

    assign douta = douta_q;
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/match_scheduler.sv
// Captures one frame, replays it 2L+2 times to a bank of matched filters and reports the best score.
// Optional collect-phase watchdog: define MATCH_SCHEDULER_TIMEOUT_EN.
module match_scheduler
  import match_scheduler_pkg::*;
#(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8,
  parameter int unsigned MATCH_SCORE_WIDTH = 32,
  parameter int unsigned CAPTURE_LENGTH    = 1000,
  parameter int unsigned NUM_FILTERS       = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 2**20
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     in_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0]             in_data,
  output logic                                     flt_rst,
  output logic                                     flt_valid,
  output logic [SAMPLE_DATA_WIDTH-1:0]             flt_data,
  input  logic [NUM_FILTERS-1:0]                   score_valid,
  input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] score_data,
  output logic                                     busy,
  output logic                                     done,
  output logic [$clog2(NUM_FILTERS)-1:0]           best_id,
  output logic [MATCH_SCORE_WIDTH-1:0]             best_score,
  output logic                                     timeout
);

  localparam int unsigned AddrW     = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam int unsigned PassW     = $clog2(2 * CAPTURE_LENGTH + 3);
  localparam int unsigned IdW       = $clog2(NUM_FILTERS);
  localparam int unsigned NumPasses = pass_count(CAPTURE_LENGTH);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(CAPTURE_LENGTH - 1);
  localparam logic [PassW-1:0] LastPass = PassW'(NumPasses);

  state_e                                          state_q, state_d;
  logic                                            clr_q, clr_d;
  logic [AddrW-1:0]                                addr_q, addr_d;
  logic                                            gap_q, gap_d;
  logic [PassW-1:0]                                pass_q, pass_d;
  logic                                            drain_q, drain_d;
  logic [1:0]                                      vld_q, vld_d;
  logic [NUM_FILTERS-1:0]                          resp_q, resp_d;
  logic [NUM_FILTERS-1:0][MATCH_SCORE_WIDTH-1:0]   score_q, score_d;
  logic [IdW-1:0]                                  best_id_q, best_id_d;
  logic [MATCH_SCORE_WIDTH-1:0]                    best_score_q, best_score_d;
  logic                                            ram_we, rd_issue, collect_en, found;
  logic [SAMPLE_DATA_WIDTH-1:0]                    ram_douta, ram_doutb;

`ifdef MATCH_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Score pulses landing in the final replay gap count as collected.
  assign collect_en = (state_q == StCollect) ||
                      (state_q == StReplay && pass_q == LastPass && drain_q);

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    addr_d       = addr_q;
    gap_d        = gap_q;
    pass_d       = pass_q;
    drain_d      = drain_q;
    resp_d       = resp_q;
    score_d      = score_q;
    best_id_d    = best_id_q;
    best_score_d = best_score_q;
    ram_we       = 1'b0;
    rd_issue     = 1'b0;
    found        = 1'b0;
`ifdef MATCH_SCHEDULER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = timeout_q;
`endif

    if (collect_en) begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (score_valid[i] && !resp_q[i]) begin
          resp_d[i]  = 1'b1;
          score_d[i] = score_data[i*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH];
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          clr_d   = 1'b0;
          resp_d  = '0;
`ifdef MATCH_SCHEDULER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StClear: begin
        if (clr_q) begin
          state_d = StCapture;
          addr_d  = '0;
        end else begin
          clr_d = 1'b1;
        end
      end
      StCapture: begin
        if (in_valid) begin
          ram_we = 1'b1;
          if (addr_q == LastAddr) begin
            state_d = StReplay;
            addr_d  = '0;
            gap_d   = 1'b0;
            pass_d  = '0;
            drain_d = 1'b0;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
      end
      StReplay: begin
        // Two drain cycles after the last pass cover the read latency; the second is the final gap.
        if (pass_q == LastPass) begin
          if (drain_q) begin
            state_d = StCollect;
`ifdef MATCH_SCHEDULER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            drain_d = 1'b1;
          end
        end else if (gap_q) begin
          gap_d  = 1'b0;
          pass_d = pass_q + PassW'(1);
        end else begin
          rd_issue = 1'b1;
          if (addr_q == LastAddr) begin
            addr_d = '0;
            gap_d  = 1'b1;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
      end
      StCollect: begin
        if (&resp_d) begin
          state_d = StReport;
        end
`ifdef MATCH_SCHEDULER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StReport;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Arbitrate on the entry edge so the result is visible alongside done.
    if (state_q == StCollect && state_d == StReport) begin
      best_id_d    = '0;
      best_score_d = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (resp_d[i] && (!found || $signed(score_d[i]) > $signed(best_score_d))) begin
          found        = 1'b1;
          best_id_d    = IdW'(i);
          best_score_d = score_d[i];
        end
      end
    end

    vld_d = {vld_q[0], rd_issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_q        <= 1'b0;
      addr_q       <= '0;
      gap_q        <= 1'b0;
      pass_q       <= '0;
      drain_q      <= 1'b0;
      vld_q        <= '0;
      resp_q       <= '0;
      score_q      <= '0;
      best_id_q    <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      addr_q       <= addr_d;
      gap_q        <= gap_d;
      pass_q       <= pass_d;
      drain_q      <= drain_d;
      vld_q        <= vld_d;
      resp_q       <= resp_d;
      score_q      <= score_d;
      best_id_q    <= best_id_d;
      best_score_q <= best_score_d;
    end
  end

`ifdef MATCH_SCHEDULER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (SAMPLE_DATA_WIDTH),
    .RAM_DEPTH       (CAPTURE_LENGTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_frame_ram (
    .addra  (addr_q),
    .addrb  (addr_q),
    .dina   ({SAMPLE_DATA_WIDTH{1'b0}}),
    .dinb   (in_data),
    .clka   (clk),
    .wea    (1'b0),
    .web    (ram_we),
    .ena    (1'b1),
    .enb    (ram_we),
    .rsta   (1'b0),
    .rstb   (1'b0),
    .regcea (1'b1),
    .regceb (1'b0),
    .douta  (ram_douta),
    .doutb  (ram_doutb)
  );

  logic unused_doutb;
  assign unused_doutb = ^ram_doutb;

  assign flt_rst    = (state_q == StClear);
  assign flt_valid  = vld_q[1];
  assign flt_data   = vld_q[1] ? ram_douta : '0;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StReport);
  assign best_id    = best_id_q;
  assign best_score = best_score_q;

endmodule

// File: tb/tb_match_scheduler.sv
// Randomized scoreboard bench for match_scheduler (L=4, N=2, TIMEOUT_CYCLES=16).
module tb_match_scheduler;

  localparam int L   = 4;
  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int W   = 32;
  localparam int TMO = 16;
  localparam int P   = 2 * L + 2;
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              flt_rst, flt_valid;
  logic [DW-1:0]     flt_data;
  logic [N-1:0]      score_valid = '0;
  logic [N*W-1:0]    score_data = '0;
  logic              busy, done, timeout;
  logic [IDW-1:0]    best_id;
  logic [W-1:0]      best_score;

  always #5 clk = ~clk;

  match_scheduler #(
    .SAMPLE_DATA_WIDTH (DW),
    .MATCH_SCORE_WIDTH (W),
    .CAPTURE_LENGTH    (L),
    .NUM_FILTERS       (N),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .flt_rst     (flt_rst),
    .flt_valid   (flt_valid),
    .flt_data    (flt_data),
    .score_valid (score_valid),
    .score_data  (score_data),
    .busy        (busy),
    .done        (done),
    .best_id     (best_id),
    .best_score  (best_score),
    .timeout     (timeout)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   score;
    logic           tmo;
  } res_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] flt_q[$];
  res_t          res_q[$];
  res_t          mon_r;
  int cyc = 0, vcnt = 0, first_vcyc = 0, last_vcyc = 0, rst_run = 0;
  bit busy_chk = 0;

  logic [DW-1:0] job_s [L];
  int            job_gap [L];
  logic [W-1:0]  job_sc [N];
  logic [N-1:0]  job_mask;
  bit            job_poke;
  int            job_abort;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: highest signed score among responders, lowest index on ties.
  function automatic res_t model();
    res_t r;
    int   mx = 0;
    bit   any = 0;
    r.id = '0; r.score = '0; r.tmo = 1'b0;
    for (int i = 0; i < N; i++)
      if (job_mask[i] && (!any || int'(job_sc[i]) > mx)) begin mx = int'(job_sc[i]); any = 1; end
    if (any) begin
      for (int i = N - 1; i >= 0; i--)
        if (job_mask[i] && int'(job_sc[i]) == mx) r.id = IDW'(i);
      r.score = W'(mx);
    end
`ifdef MATCH_SCHEDULER_TIMEOUT_EN
    r.tmo = (job_mask != {N{1'b1}});
`endif
    return r;
  endfunction

  // Monitor: replay stream, gap spacing, clear width and job results.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      vcnt = 0; rst_run = 0; busy_chk = 0;
    end else begin
      if (busy_chk) begin check("busy_after_done", busy, 0); busy_chk = 0; end
      if (flt_rst) begin
        rst_run++; vcnt = 0;
      end else if (rst_run != 0) begin
        check("flt_rst_width", rst_run, 2); rst_run = 0;
      end
      if (flt_valid) begin
        check("flt_expected", flt_q.size() > 0, 1);
        if (flt_q.size() > 0) check("flt_data", flt_data, flt_q.pop_front());
        if (vcnt == 0) first_vcyc = cyc;
        else check("flt_spacing", cyc - first_vcyc, vcnt + vcnt / L);
        vcnt++;
        last_vcyc = cyc;
      end else if (busy) begin
        check("flt_data_idle", flt_data, 0);
      end
      if (done) begin
        check("done_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          mon_r = res_q.pop_front();
          check("best_id", best_id, mon_r.id);
          check("best_score", best_score, mon_r.score);
          check("timeout", timeout, mon_r.tmo);
          check("busy_at_done", busy, 1);
          check("valid_total", vcnt, P * L);
          check("stream_drained", flt_q.size(), 0);
          if (mon_r.tmo) check("timeout_latency", cyc - last_vcyc, TMO + 2);
        end
        busy_chk = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job();
    int t;
    int dly [N];
    for (int p = 0; p < P; p++)
      for (int i = 0; i < L; i++) flt_q.push_back(job_s[i]);
    if (job_abort == 0) res_q.push_back(model());
    start = 1; tick();
    start = 0; in_valid = 1; in_data = 8'hEE; tick();
    in_valid = 0; tick();
    for (int i = 0; i < L; i++) begin
      in_valid = 1; in_data = job_s[i]; tick();
      in_valid = 0;
      for (int g = 0; g < job_gap[i]; g++) begin
        in_data = DW'($urandom);
        start = job_poke && (g == 0);
        tick();
      end
      start = 0;
    end
    if (job_abort != 0) begin
      t = 0;
      while (vcnt < job_abort && t < 300) begin tick(); t++; end
      check("abort_reached", vcnt >= job_abort, 1);
      @(posedge clk); #2;
      rst_n = 0; #1;
      check("rst_flt_valid", flt_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_flt_rst", flt_rst, 0);
      check("rst_done", done, 0);
      flt_q.delete();
      res_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      tick();
      return;
    end
    repeat (3) tick();
    start = job_poke; in_valid = 1; in_data = 8'h5A; tick();
    start = 0; in_valid = 0;
    t = 0;
    while (vcnt < P * L && t < 300) begin tick(); t++; end
    check("replay_len", vcnt, P * L);
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 4);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        score_valid[i] = job_mask[i] && (c == dly[i] || c == dly[i] + 2);
        score_data[i*W +: W] = (c == dly[i]) ? job_sc[i] : W'($urandom);
      end
      tick();
    end
    score_valid = '0;
    t = 0;
    while (res_q.size() != 0 && t < TMO + 60) begin tick(); t++; end
    check("done_seen", res_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic set_ref_job();
    job_s[0] = 8'd10; job_s[1] = 8'd20; job_s[2] = 8'd30; job_s[3] = 8'd40;
    job_gap[0] = 0; job_gap[1] = 1; job_gap[2] = 0; job_gap[3] = 0;
    job_sc[0] = 32'd100; job_sc[1] = 32'd250;
    job_mask = '1; job_poke = 1; job_abort = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    check("reset_flt_rst", flt_rst, 0);
    check("reset_flt_valid", flt_valid, 0);
    check("reset_flt_data", flt_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_best_id", best_id, 0);
    check("reset_best_score", best_score, 0);
    check("reset_timeout", timeout, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    tick();

    set_ref_job();
    run_job();

    set_ref_job();
    job_sc[0] = 32'hFFFF_FFFB; job_sc[1] = 32'hFFFF_FFFB; job_poke = 0;
    run_job();

    set_ref_job();
    for (int i = 0; i < L; i++) job_s[i] = DW'($urandom);
    job_abort = 2 * L + 1;
    run_job();
    check("post_reset_timeout", timeout, 0);

    set_ref_job();
    run_job();

`ifdef MATCH_SCHEDULER_TIMEOUT_EN
    set_ref_job();
    job_sc[0] = 32'd7; job_mask = 2'b01; job_poke = 0;
    run_job();
    check("timeout_held", timeout, 1);
`endif

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < L; i++) begin
        job_s[i] = DW'($urandom);
        job_gap[i] = $urandom_range(0, 2);
      end
      for (int i = 0; i < N; i++) job_sc[i] = W'($urandom);
      if ($urandom_range(0, 2) == 0) job_sc[1] = job_sc[0];
      job_gap[0] = 1;
      job_mask = '1;
      job_poke = ($urandom_range(0, 1) == 1);
      job_abort = 0;
      run_job();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
